// File: rtl/bcd_to_binary_converter_pkg.sv
// bcd_to_binary_converter_pkg: shared FSM states and BCD constants for the BCD-to-binary converter
package bcd_to_binary_converter_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int NIB_W     = 4;
  localparam int CORR_TH   = 8;
  localparam int CORR_OFF  = 3;
  localparam int DIGIT_MAX = 9;
endpackage

// File: rtl/bcd_to_binary_converter_bcd_digit_correct.sv
// bcd_digit_correct: reverse double-dabble nibble fix-up, subtracts 3 from a nibble >= 8
//   nib_i  in  NIB_W  nibble after the right shift
//   nib_o  out NIB_W  corrected nibble
module bcd_digit_correct
  import bcd_to_binary_converter_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [NIB_W-1:0] nib_o
);
  assign nib_o = (nib_i >= NIB_W'(CORR_TH)) ? nib_i - NIB_W'(CORR_OFF) : nib_i;
endmodule

// File: rtl/bcd_to_binary_converter.sv
// bcd_to_binary_converter: sequential reverse double-dabble, packed BCD in, unsigned binary out
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   request handshake, bcd_in captured when both high
//   bcd_in              packed BCD, digit 0 in [3:0]
//   out_valid           one-cycle result strobe
//   bin_out, err        registered result; err flags a nibble > 9 (result forced to 0)
module bcd_to_binary_converter
  import bcd_to_binary_converter_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIB_W*DIGITS-1:0] bcd_in,
  output logic                    out_valid,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);
  localparam int BCD_W = NIB_W * DIGITS;
  localparam int CW    = $clog2(BIN_W);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, sh_bcd, corr_bcd;
  logic [BIN_W-1:0] bin_q, bin_d, sh_bin, bin_out_q, bin_out_d;
  logic             out_valid_q, out_valid_d, err_q, err_d, bad_digit;
  // The BCD LSB falls into the binary MSB as the whole work register shifts right.
  assign {sh_bcd, sh_bin} = {1'b0, bcd_q, bin_q[BIN_W-1:1]};
  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_correct u_corr (
      .nib_i(sh_bcd[NIB_W*g +: NIB_W]),
      .nib_o(corr_bcd[NIB_W*g +: NIB_W])
    );
  end
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad_digit = bad_digit | (bcd_in[NIB_W*i +: NIB_W] > NIB_W'(DIGIT_MAX));
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        bcd_d = bcd_in;
        bin_d = '0;
        cnt_d = '0;
        state_d = bad_digit ? DONE : SHIFT;
        if (bad_digit) begin
          bin_out_d = '0;
          err_d     = 1'b1;
        end
      end
      SHIFT: begin
        bcd_d = corr_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) begin
          state_d   = DONE;
          bin_out_d = sh_bin;
          err_d     = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bin_q       <= '0;
      bin_out_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      bin_out_q   <= bin_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_out_q;
  assign err       = err_q;
  // A legal input is fully drained out of the BCD half once all shifts are done.
  a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !err_q) |-> (bcd_q == '0));
endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// tb_bcd_to_binary_converter: scoreboard bench for the BCD-to-binary converter
module tb_bcd_to_binary_converter;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  typedef struct {
    int bin;
    int err;
    int acc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] bcd_in = '0;
  logic        out_valid;
  logic [BIN_W-1:0] bin_out;
  logic        err;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_ov = -1;
  logic        spacing_on = 1'b0;
  logic        prev_ov = 1'b0;
  exp_t        sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bcd_to_binary_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bcd_in(bcd_in),
    .out_valid(out_valid),
    .bin_out(bin_out),
    .err(err)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [11:0] b, input int acc);
    exp_t e;
    int   d0, d1, d2;
    d0 = int'(b[3:0]);
    d1 = int'(b[7:4]);
    d2 = int'(b[11:8]);
    e.err = (d0 > 9 || d1 > 9 || d2 > 9) ? 1 : 0;
    e.bin = e.err != 0 ? 0 : d2 * 100 + d1 * 10 + d0;
    e.acc = acc;
    return e;
  endfunction
  task automatic send(input logic [11:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", int'(in_ready), 1);
    else begin
      in_valid = 1'b1;
      bcd_in   = b;
      sb.push_back(model(b, cyc + 1));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_ov) check("ready_after", int'(in_ready), 1);
      if (out_valid) begin
        check("pulse", int'(prev_ov), 0);
        check("ready_busy", int'(in_ready), 0);
        if (sb.size() == 0) check("unexpected_out", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("bin", int'(bin_out), e.bin);
          check("err", int'(err), e.err);
          check("latency", cyc - e.acc, e.err != 0 ? 0 : BIN_W);
        end
        if (spacing_on && last_ov >= 0) check("spacing", cyc - last_ov, BIN_W + 2);
        last_ov = cyc;
      end
    end
    prev_ov = out_valid;
  end
  initial begin
    logic [11:0] v;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_bin_out", int'(bin_out), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(12'h999);
    send(12'h000);
    send(12'h255);
    send(12'h100);
    send(12'h1A5);
    send(12'h042);
    drain();
    spacing_on = 1'b1;
    last_ov    = -1;
    in_valid   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
      bcd_in = v;
      if (in_ready) sb.push_back(model(v, cyc + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    spacing_on = 1'b0;
    send(12'h777);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_bin_out", int'(bin_out), 0);
    check("abort_err", int'(err), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("release_in_ready", int'(in_ready), 1);
    repeat (20) @(negedge clk);
    check("abort_no_out", int'(out_valid), 0);
    send(12'h777);
    drain();
    for (int i = 0; i < 1000; i++)
      send({4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)});
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
